sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 5, number of requesters (0 = pacman, 1-4 = ghosts).
REQ-002 SHALL have parameter ADDR_W, default 13, sprite ROM address width.
REQ-003 SHALL have parameter DATA_W, default 4, sprite ROM palette-index width.
REQ-004 SHALL have port Clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port frame_start, input, 1, one-cycle pulse at start of frame.
REQ-007 SHALL have port req, input, NUM_REQ, per-requester read request.
REQ-008 SHALL have port req_addr, input, NUM_REQ*ADDR_W, packed addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port gnt, output, NUM_REQ, one-hot grant.
REQ-010 SHALL have port rom_en, output, 1, ROM read enable.
REQ-011 SHALL have port rom_addr, output, ADDR_W, ROM address.
REQ-012 SHALL have port rom_data, input, DATA_W, ROM data, valid one cycle after rom_en.
REQ-013 SHALL have port rd_valid, output, 1, return data valid.
REQ-014 SHALL have port rd_id, output, clog2(NUM_REQ), requester owning rd_data.
REQ-015 SHALL have port rd_data, output, DATA_W, returned palette index.

Function
REQ-016 SHALL compute gnt combinationally: at most one bit high, only for a requester with req high.
REQ-017 SHALL select the first requester with req high searching upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-018 SHALL drive rom_en = |gnt and rom_addr = granted requester's address in the same cycle; rom_addr = 0 when no grant.
REQ-019 SHALL, on a grant to requester k, load rr_ptr with k+1, or 0 when k = NUM_REQ-1.
REQ-020 SHALL leave rr_ptr unchanged in cycles with no grant.
REQ-021 SHALL register grant-valid and granted id, driving rd_valid and rd_id exactly one cycle after rom_en.
REQ-022 SHALL drive rd_data = rom_data, unregistered, while rd_valid is high; 0 otherwise.
REQ-023 SHALL sustain one grant per cycle back-to-back, with no bubble between grants.
REQ-024 SHALL require requesters to hold req and address until gnt; a request dropped before gnt is discarded with no response.
REQ-025 SHALL, on frame_start, force rr_ptr to 0 for the next cycle's arbitration; a grant issued in the frame_start cycle still completes normally.
REQ-026 SHALL give frame_start precedence over the REQ-019 pointer update when both occur in the same cycle.

Reset
REQ-027 SHALL, while Reset is high, set gnt = 0, rom_en = 0, rom_addr = 0, rd_valid = 0, rd_id = 0, rd_data = 0 and rr_ptr = 0.
REQ-028 SHALL drop any read in flight when Reset asserts; no rd_valid for it after Reset deasserts.
REQ-029 SHALL accept requests on the first cycle after Reset deasserts.

Configuration
REQ-030 SHALL honour macro SPRITE_ARB_PACMAN_PRIO_EN: when defined, requester 0 wins whenever req[0] is high, rr_ptr unchanged by such grants; round robin applies among requesters 1..NUM_REQ-1 otherwise.
REQ-031 SHALL, without SPRITE_ARB_PACMAN_PRIO_EN, treat all requesters equally under REQ-017.

Structure
REQ-032 SHALL take NUM_REQ default, ADDR_W, DATA_W, ROM latency constant (1) and requester-index enum (REQ_PACMAN, REQ_GHOST0..3) from shared package sprite_pkg.
REQ-033 SHALL contain one sub-module rr_pick (combinational rotate-and-priority-encode: req, rr_ptr -> one-hot gnt); all state stays in sprite_rom_arbiter.

Verification
REQ-034 SHALL test: after Reset, req=5'b00001, req_addr[0]=13'h0123 -> gnt=00001, rom_addr=0x123 same cycle; next cycle rd_valid=1, rd_id=0, rd_data=ROM[0x123].
REQ-035 SHALL test: req=5'b11111 held 10 cycles from rr_ptr=0 -> grant order 0,1,2,3,4,0,1,2,3,4; rd_id trails by one cycle; no idle cycle.
REQ-036 SHALL test: rr_ptr=3, req=5'b00101 -> gnt=00001 (wrap), then gnt=00100.
REQ-037 SHALL test: frame_start with rr_ptr=2, req=5'b11111 -> next grant to requester 0.
REQ-038 SHALL test: Reset asserted the cycle after a grant -> rd_valid stays 0 throughout and after reset.
REQ-039 SHALL test, with SPRITE_ARB_PACMAN_PRIO_EN: req=5'b10011 held 4 cycles, req[0] dropped in cycle 3 -> gnt 00001, 00001, 00010, 10000.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sizing defaults, ROM timing and requester identities for the sprite ROM arbiter.
// Requester 0 is pacman; 1..4 are the ghosts.
package sprite_pkg;
    localparam int NUM_REQ_DEF = 5;
    localparam int ADDR_W_DEF  = 13;
    localparam int DATA_W_DEF  = 4;
    localparam int ROM_LAT     = 1;

    typedef enum logic [2:0] {
        REQ_PACMAN = 3'd0,
        REQ_GHOST0 = 3'd1,
        REQ_GHOST1 = 3'd2,
        REQ_GHOST2 = 3'd3,
        REQ_GHOST3 = 3'd4
    } req_idx_e;
endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first active request at or above i_ptr, wrapping to 0; one-hot result.
// Purely combinational, no state.
module rr_pick
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);
    // One spare bit so ptr + offset cannot overflow before the wrap subtract.
    logic [PTR_W:0] w_idx;
    logic           w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_idx >= (PTR_W+1)'(NUM_REQ))
                w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
            if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
                o_gnt[w_idx[PTR_W-1:0]] = 1'b1;
                w_found                 = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: one combinational grant per cycle, response one cycle later; optional pacman priority via SPRITE_ARB_PACMAN_PRIO_EN.
// Requesters hold req/address until granted; no other backpressure.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rd_valid,
    output logic [ID_W-1:0]           rd_id,
    output logic [DATA_W-1:0]         rd_data
);
    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_rd_vld;
    logic [ID_W-1:0]    r_rd_id;
    logic [NUM_REQ-1:0] w_pick_req;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_prio_hit;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ADDR_W-1:0]  w_addr;
    logic [ID_W-1:0]    w_ptr_nxt;

`ifdef SPRITE_ARB_PACMAN_PRIO_EN
    assign w_prio_hit = req[int'(REQ_PACMAN)];
    assign w_pick_req = req & ~(NUM_REQ'(1) << int'(REQ_PACMAN));
`else
    assign w_prio_hit = 1'b0;
    assign w_pick_req = req;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr_pick (
        .i_req (w_pick_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt)
    );

    always_comb begin
        w_gnt = w_pick_gnt;
        if (w_prio_hit)
            w_gnt = NUM_REQ'(1) << int'(REQ_PACMAN);
        if (Reset)
            w_gnt = '0;
    end

    always_comb begin
        w_gnt_id = '0;
        w_addr   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_id = ID_W'(i);
                w_addr   = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Priority grants to pacman leave the rotation untouched; frame_start overrides everything.
    always_comb begin
        w_ptr_nxt = r_rr_ptr;
        if (|w_gnt && !w_prio_hit)
            w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;
        if (frame_start)
            w_ptr_nxt = '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rr_ptr <= '0;
            r_rd_vld <= 1'b0;
            r_rd_id  <= '0;
        end else begin
            r_rr_ptr <= w_ptr_nxt;
            r_rd_vld <= |w_gnt;
            r_rd_id  <= w_gnt_id;
        end
    end

    assign gnt      = w_gnt;
    assign rom_en   = |w_gnt;
    assign rom_addr = w_addr;
    assign rd_valid = r_rd_vld & ~Reset;
    assign rd_id    = Reset ? '0 : r_rd_id;
    assign rd_data  = rd_valid ? rom_data : '0;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a scoreboard of expected read responses.
module tb_sprite_rom_arbiter;
    localparam int N  = 5;
    localparam int AW = 13;
    localparam int DW = 4;

    logic          Clk;
    logic          Reset;
    logic          frame_start;
    logic [N-1:0]  req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]  gnt;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rd_valid;
    logic [2:0]    rd_id;
    logic [DW-1:0] rd_data;

    typedef struct {
        logic [2:0]    id;
        logic [DW-1:0] dat;
    } rsp_t;

    rsp_t          sb[$];
    logic [AW-1:0] addr_tab[N];
    int            checks   = 0;
    int            failures = 0;

    sprite_rom_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rd_valid    (rd_valid),
        .rd_id       (rd_id),
        .rd_data     (rd_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ {3'b000, a[12]} ^ 4'h9;
    endfunction

    // One-cycle-latency ROM model
    always @(posedge Clk) begin
        if (rom_en)
            rom_data <= rom_f(rom_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic fs, input logic [N-1:0] rq,
                        input logic [N-1:0] exp_gnt, input string tag);
        rsp_t          r;
        logic [AW-1:0] exp_addr;
        logic [2:0]    exp_id;
        @(negedge Clk);
        Reset       = rst;
        frame_start = fs;
        req         = rq;
        #1;
        if (rst) begin
            sb.delete();
            chk({tag, ".rd_id"}, 32'(rd_id), 32'd0);
        end
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, ".rd_id"},    32'(rd_id),    32'(r.id));
            chk({tag, ".rd_data"},  32'(rd_data),  32'(r.dat));
        end else begin
            chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
            chk({tag, ".rd_data"},  32'(rd_data),  32'd0);
        end
        exp_addr = '0;
        exp_id   = '0;
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) begin
                exp_addr = addr_tab[i];
                exp_id   = 3'(i);
            end
        end
        chk({tag, ".gnt"},      32'(gnt),      32'(exp_gnt));
        chk({tag, ".rom_en"},   32'(rom_en),   32'(|exp_gnt));
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(exp_addr));
        if (|exp_gnt) begin
            r.id  = exp_id;
            r.dat = rom_f(exp_addr);
            sb.push_back(r);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            addr_tab[i] = 13'h0123 + AW'(i) * 13'h0211;
            req_addr[i*AW +: AW] = addr_tab[i];
        end
        Reset       = 1'b1;
        frame_start = 1'b0;
        req         = '0;
        rom_data    = '0;

        step(1'b1, 1'b0, 5'b11111, 5'b00000, "rst0");
        step(1'b1, 1'b0, 5'b11111, 5'b00000, "rst1");

        step(1'b0, 1'b0, 5'b00001, 5'b00001, "single");
        step(1'b0, 1'b1, 5'b00000, 5'b00000, "single_rsp");

        for (int k = 0; k < 10; k++)
            step(1'b0, 1'b0, 5'b11111, 5'b00001 << (k % 5), "rr_all");
        step(1'b0, 1'b0, 5'b00000, 5'b00000, "rr_tail");

        step(1'b0, 1'b0, 5'b00100, 5'b00100, "set_ptr3");
        step(1'b0, 1'b0, 5'b00101, 5'b00001, "wrap");
        step(1'b0, 1'b0, 5'b00100, 5'b00100, "after_wrap");

        step(1'b0, 1'b0, 5'b00010, 5'b00010, "set_ptr2");
        step(1'b0, 1'b1, 5'b11111, 5'b00100, "fs_grant");
        step(1'b0, 1'b0, 5'b11111, 5'b00001, "fs_next");

        step(1'b0, 1'b0, 5'b00010, 5'b00010, "pre_rst");
        step(1'b1, 1'b0, 5'b00010, 5'b00000, "rst_mid");
        step(1'b0, 1'b0, 5'b00001, 5'b00001, "post_rst");
        step(1'b0, 1'b0, 5'b00000, 5'b00000, "post_rst_rsp");

`ifdef SPRITE_ARB_PACMAN_PRIO_EN
        step(1'b0, 1'b0, 5'b10011, 5'b00001, "prio1");
        step(1'b0, 1'b0, 5'b10011, 5'b00001, "prio2");
        step(1'b0, 1'b0, 5'b10010, 5'b00010, "prio3");
        step(1'b0, 1'b0, 5'b10010, 5'b10000, "prio4");
`else
        step(1'b0, 1'b0, 5'b10011, 5'b00010, "fair1");
        step(1'b0, 1'b0, 5'b10011, 5'b10000, "fair2");
        step(1'b0, 1'b0, 5'b10010, 5'b00010, "fair3");
        step(1'b0, 1'b0, 5'b10010, 5'b10000, "fair4");
`endif
        step(1'b0, 1'b0, 5'b00000, 5'b00000, "final_rsp");
        step(1'b0, 1'b0, 5'b00000, 5'b00000, "idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
